// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Registered immediate extender with a valid/ready handshake and a
//   2-entry skid buffer. It sits between the instruction-decode register
//   and the ALU-B / branch-adder muxes.
//
//   ExtMode: 00 zero-extend, 01 sign-extend,
//            10 upper (imm << (OUT_W-IN_W)), 11 sign-extend then << SHIFT.
//
// Ports
//   CLK             clock, rising edge
//   Reset           asynchronous active-low reset
//   immediate       raw IN_W-bit immediate field
//   ExtMode         extension mode
//   in_valid        immediate/ExtMode valid this cycle
//   in_ready        block can accept input (depends only on state)
//   extendImmediate OUT_W-bit extended result of the presented entry
//   sign_out        immediate[IN_W-1] of the presented entry
//   out_valid       extendImmediate is valid
//   out_ready       consumer accepts this cycle
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [IN_W-1:0]  immediate,
  input  logic [1:0]       ExtMode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] extendImmediate,
  output logic             sign_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  m_res_q, m_res_d;
  logic              m_sign_q, m_sign_d;
  logic [OUT_W-1:0]  s_res_q, s_res_d;
  logic              s_sign_q, s_sign_d;

  logic [OUT_W-1:0]  zext;
  logic [OUT_W-1:0]  sext;
  logic [OUT_W-1:0]  new_res;
  logic              new_sign;
  logic              in_xfer;
  logic              out_xfer;

  // Extension is computed on the input side so the output is a plain register.
  always_comb begin
    zext     = {{PAD{1'b0}}, immediate};
    sext     = {{PAD{immediate[IN_W-1]}}, immediate};
    new_sign = immediate[IN_W-1];
    case (ExtMode)
      2'b00:   new_res = zext;
      2'b01:   new_res = sext;
      2'b10:   new_res = {immediate, {PAD{1'b0}}};
      default: new_res = sext << SHIFT;
    endcase
  end

  assign in_ready        = (state_q != ST_FULL);
  assign out_valid       = (state_q != ST_EMPTY);
  assign extendImmediate = m_res_q;
  assign sign_out        = m_sign_q;

  assign in_xfer  = in_valid  & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_res_d  = m_res_q;
    m_sign_d = m_sign_q;
    s_res_d  = s_res_q;
    s_sign_d = s_sign_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          m_res_d  = new_res;
          m_sign_d = new_sign;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          m_res_d  = new_res;
          m_sign_d = new_sign;
        end else if (in_xfer) begin
          s_res_d  = new_res;
          s_sign_d = new_sign;
          state_d  = ST_FULL;
        end else if (out_xfer) begin
          // M keeps its last value so the idle output does not change.
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          m_res_d  = s_res_q;
          m_sign_d = s_sign_q;
          s_res_d  = '0;
          s_sign_d = 1'b0;
          state_d  = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_EMPTY;
      m_res_q  <= '0;
      m_sign_q <= 1'b0;
      s_res_q  <= '0;
      s_sign_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_res_q  <= m_res_d;
      m_sign_q <= m_sign_d;
      s_res_q  <= s_res_d;
      s_sign_q <= s_sign_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and scoreboarded checks for imm_extend_pipe, default build and
// an IN_W=12 / SHIFT=1 build.
module tb_imm_extend_pipe;

  logic        CLK;
  logic        Reset;
  logic [15:0] immediate;
  logic [1:0]  ExtMode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] extendImmediate;
  logic        sign_out;
  logic        out_valid;
  logic        out_ready;

  logic [11:0] imm2;
  logic [1:0]  mode2;
  logic        iv2;
  logic        ir2;
  logic [31:0] ext2;
  logic        so2;
  logic        ov2;
  logic        ordy2;

  int n_checks = 0;
  int n_pass   = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
    .CLK(CLK), .Reset(Reset), .immediate(immediate), .ExtMode(ExtMode),
    .in_valid(in_valid), .in_ready(in_ready),
    .extendImmediate(extendImmediate), .sign_out(sign_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(32), .SHIFT(1)) dut12 (
    .CLK(CLK), .Reset(Reset), .immediate(imm2), .ExtMode(mode2),
    .in_valid(iv2), .in_ready(ir2),
    .extendImmediate(ext2), .sign_out(so2),
    .out_valid(ov2), .out_ready(ordy2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model written independently of the RTL structure.
  function automatic logic [32:0] model(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] r;
    case (mode)
      2'd0:    r = {16'h0000, imm};
      2'd1:    r = {{16{imm[15]}}, imm};
      2'd2:    r = {imm, 16'h0000};
      default: r = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return {imm[15], r};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] vimm [4];
  logic [1:0]  vmode [4];
  logic [31:0] vexp [4];
  logic [32:0] q [$];
  logic [32:0] prev_val;
  logic        prev_stall;
  int pushed, popped, spurious, cyc;

  initial begin
    Reset = 1'b0; immediate = '0; ExtMode = '0; in_valid = 1'b0; out_ready = 1'b0;
    imm2 = '0; mode2 = '0; iv2 = 1'b0; ordy2 = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ext", extendImmediate, 0);
    chk("rst_sign", sign_out, 0);
    Reset = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // 1: fill to FULL, then reset mid-cycle
    out_ready = 1'b0;
    in_valid = 1'b1; immediate = 16'h8123; ExtMode = 2'd1;
    tick();
    immediate = 16'h4567; ExtMode = 2'd0;
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    Reset = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_ext", extendImmediate, 0);
    chk("async_sign", sign_out, 0);
    tick();
    Reset = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_no_stale", out_valid, 0);

    // 2: 0x8001 in all four modes back to back
    vimm[0] = 16'h8001; vmode[0] = 2'd0; vexp[0] = 32'h00008001;
    vimm[1] = 16'h8001; vmode[1] = 2'd1; vexp[1] = 32'hFFFF8001;
    vimm[2] = 16'h8001; vmode[2] = 2'd2; vexp[2] = 32'h80010000;
    vimm[3] = 16'h8001; vmode[3] = 2'd3; vexp[3] = 32'hFFFE0004;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; immediate = vimm[i]; ExtMode = vmode[i];
      tick();
      chk($sformatf("mode%0d_valid", i), out_valid, 1);
      chk($sformatf("mode%0d_ext", i), extendImmediate, vexp[i]);
      chk($sformatf("mode%0d_sign", i), sign_out, 1);
    end

    // 3: positive sign-extend and all-ones branch offset
    immediate = 16'h7FFF; ExtMode = 2'd1;
    tick();
    chk("pos_sext", extendImmediate, 32'h00007FFF);
    chk("pos_sign", sign_out, 0);
    immediate = 16'hFFFF; ExtMode = 2'd3;
    tick();
    chk("neg_shift", extendImmediate, 32'hFFFFFFFC);
    in_valid = 1'b0;
    tick();
    chk("drained", out_valid, 0);
    chk("idle_hold", extendImmediate, 32'hFFFFFFFC);

    // 4: back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; immediate = 16'h1234; ExtMode = 2'd0;
    tick();
    chk("bp_a_out", extendImmediate, 32'h00001234);
    chk("bp_one_ready", in_ready, 1);
    immediate = 16'hF000; ExtMode = 2'd1;
    tick();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_hold_a", extendImmediate, 32'h00001234);
    immediate = 16'h0BAD; ExtMode = 2'd2;
    tick();
    chk("bp_c_refused_hold", extendImmediate, 32'h00001234);
    chk("bp_still_full", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_a_present", extendImmediate, 32'h00001234);
    tick();
    chk("bp_b_out", extendImmediate, 32'hFFFFF000);
    chk("bp_b_valid", out_valid, 1);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_no_c", out_valid, 0);

    // 5: random traffic against a scoreboard
    pushed = 0; popped = 0; spurious = 0; cyc = 0; prev_stall = 1'b0; prev_val = '0;
    while ((pushed < 100 || q.size() > 0) && cyc < 3000) begin
      in_valid  = (pushed < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      immediate = 16'($urandom);
      ExtMode   = 2'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) chk("stall_hold", {sign_out, extendImmediate}, prev_val);
      if (in_valid && in_ready) begin
        q.push_back(model(immediate, ExtMode));
        pushed++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) spurious++;
        else chk("sb_order", {sign_out, extendImmediate}, q.pop_front());
        popped++;
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = {sign_out, extendImmediate};
      @(posedge CLK);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("sb_popped", popped, 100);
    chk("sb_empty", q.size(), 0);
    chk("sb_spurious", spurious, 0);

    // 6: IN_W=12, SHIFT=1 build
    iv2 = 1'b1; imm2 = 12'h800; mode2 = 2'd1;
    tick();
    chk("w12_sext", ext2, 32'hFFFFF800);
    chk("w12_sign", so2, 1);
    mode2 = 2'd2;
    tick();
    chk("w12_upper", ext2, 32'h80000000);
    mode2 = 2'd3;
    tick();
    chk("w12_shift", ext2, 32'hFFFFF000);
    chk("w12_valid", ov2, 1);
    iv2 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
